// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the writeback path.
package regfile_pkg;
  localparam int XLEN     = 64;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xdata_t;

  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// rr_arbiter: combinational N-way arbiter producing a one-hot grant and the
// binary winner index. Round-robin searches from ptr+1 with wrap-around.
// When WBARB_FIXED_PRIO_EN is defined it becomes a fixed-priority arbiter
// (lowest index wins) and the ptr port disappears.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
`ifndef WBARB_FIXED_PRIO_EN
  input  logic [PW-1:0] ptr,
`endif
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] win
);
  logic found;

  // First valid request in search order wins; gnt stays zero when idle.
  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
`ifdef WBARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) begin
      if (!found && req[k]) begin
        found  = 1'b1;
        win    = PW'(k);
        gnt[k] = 1'b1;
      end
    end
`else
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found                       = 1'b1;
        win                         = PW'((int'(ptr) + k) % N);
        gnt[(int'(ptr) + k) % N]    = 1'b1;
      end
    end
`endif
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port among NUM_REQ
// writeback sources. One winner per cycle is registered onto rf_we/rf_rd/rf_wd;
// writes to x0 are granted but dropped. Also tracks a busy scoreboard of
// destination registers with writes in flight.
// Build option: WBARB_FIXED_PRIO_EN selects fixed priority (index 0 highest)
// instead of the default round-robin.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = regfile_pkg::XLEN,
  parameter int REG_AW  = regfile_pkg::REG_AW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*REG_AW-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0]   req_wd,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      iss_valid,
  input  logic [REG_AW-1:0]         iss_rd,
  output logic                      rf_we,
  output logic [REG_AW-1:0]         rf_rd,
  output logic [XLEN-1:0]           rf_wd,
  output logic [31:0]               busy
);
  import regfile_pkg::*;

  localparam int PW = $clog2(NUM_REQ);

  // Flattened buses viewed as per-requester lanes (same bit layout).
  logic [NUM_REQ-1:0][REG_AW-1:0] rd_arr;
  logic [NUM_REQ-1:0][XLEN-1:0]   wd_arr;
  assign rd_arr = req_rd;
  assign wd_arr = req_wd;

  logic [PW-1:0]       win;
  logic                hs;
  logic [NUM_REGS-1:0] busy_nxt;

  // Any valid request is always granted, so a handshake happens whenever
  // something is valid.
  assign hs = |req_valid;

`ifdef WBARB_FIXED_PRIO_EN
  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req (req_valid),
    .gnt (req_ready),
    .win (win)
  );
`else
  logic [PW-1:0] ptr;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (req_ready),
    .win (win)
  );

  // Round-robin pointer remembers the last winner; reset value makes
  // requester 0 the first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ptr <= PW'(NUM_REQ - 1);
    else if (hs) ptr <= win;
  end
`endif

  // Register the winner onto the write port; x0 targets never assert rf_we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wd <= '0;
    end else if (hs) begin
      rf_we <= (rd_arr[win] != '0);
      rf_rd <= rd_arr[win];
      rf_wd <= wd_arr[win];
    end else begin
      rf_we <= 1'b0;
    end
  end

  // Scoreboard update: clear on the RF write edge, then set from issue so a
  // newer producer of the same register keeps it busy. x0 is never busy.
  always_comb begin
    busy_nxt = busy;
    if (rf_we) busy_nxt[rf_rd] = 1'b0;
    if (iss_valid && iss_rd != '0) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port among NUM_REQ writeback requesters (ALU, load unit, mul/div).
- Arbitrates once per cycle, registers the winner onto the write port, and drops writes to x0.
- Keeps a busy scoreboard of registers with writes in flight, which issue logic uses for RAW stalls.
- Sits between the execute/memory units and the register file write port (we, rd, wd).

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- XLEN, 64, data width of the write port.
- REG_AW, 5, register address width (32 registers).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester writeback valid.
- req_rd  in  NUM_REQ*REG_AW  flattened destination addresses; slice i is requester i.
- req_wd  in  NUM_REQ*XLEN  flattened write data.
- req_ready  out  NUM_REQ  one-hot grant/accept.
- iss_valid  in  1  an instruction with a destination register is issuing this cycle.
- iss_rd  in  REG_AW  destination register of the issuing instruction.
- rf_we  out  1  register file write enable (registered).
- rf_rd  out  REG_AW  register file write address (registered).
- rf_wd  out  XLEN  register file write data (registered).
- busy  out  32  scoreboard; bit r set means a write to xr is pending. Bit 0 is always 0.

Behaviour:
- Reset (async, rst_n=0):
  - rf_we=0, rf_rd=0, rf_wd=0, busy=0.
  - Round-robin pointer ptr=NUM_REQ-1, so requester 0 has first priority after reset.
- Grant (combinational):
  - Search req_valid starting at index (ptr+1) mod NUM_REQ, wrapping around.
  - The first valid index wins; req_ready[win]=1, all other ready bits 0.
  - With no valid request, req_ready=0.
  - req_ready depends combinationally on req_valid. Requesters must not make valid depend on ready.
  - A handshake completes when req_valid[i] and req_ready[i] are both 1 at a posedge.
- Pointer: on a completed handshake, ptr <= win; otherwise ptr holds.
- Output stage, one-cycle latency:
  - On a handshake at edge T: rf_we <= (winner rd != 0), rf_rd <= winner rd, rf_wd <= winner wd.
  - With no handshake: rf_we <= 0, and rf_rd/rf_wd hold their values.
  - The register file writes at edge T+1.
- x0 requests: still granted, and ptr still advances, but rf_we=0 and no scoreboard effect.
- No output backpressure: the write port always accepts, so at most one request is consumed per cycle.
- Unserved requesters must hold valid/rd/wd stable until granted.
- Scoreboard, per posedge:
  - Set: busy[iss_rd] <= 1 if iss_valid and iss_rd != 0.
  - Clear: busy[rf_rd] <= 0 if rf_we=1. The clear coincides with the register file write edge, so a read after busy drops returns the new value.
  - Set and clear of the same register on the same edge: set wins (a newer producer is in flight).
  - A clear of a register that is not busy is harmless.
- Reset mid-operation:
  - All pending grants are discarded and busy is cleared.
  - Upstream must flush its in-flight instructions alongside reset.

Optional Feature:
- Macro WBARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins every cycle; ptr is neither present nor updated. Starvation is permitted, and the load unit must be placed at index 0.
- Undefined (default): round-robin as described in Behaviour.

Decomposition:
- Package regfile_pkg:
  - XLEN=64, REG_AW=5, NUM_REGS=32.
  - Type reg_addr_t (logic [REG_AW-1:0]) and type xdata_t (logic [XLEN-1:0]).
  - Constant REG_ZERO='0.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req vector, ptr, and the fixed-priority macro.
  - Outputs: one-hot gnt and binary win index.
  - Purely combinational; reusable for the memory port later.

Test Plan:
- Reset mid-traffic: busy=0x000000F0 and rf_we=1, assert rst_n=0 → busy=0, rf_we=0, rf_rd=0 immediately (async). After release, the first grant goes to requester 0.
- Single write: req_valid=3'b010, rd=7, wd=64'hDEAD_BEEF at edge T → req_ready=3'b010 in cycle T. In T+1: rf_we=1, rf_rd=7, rf_wd=64'hDEAD_BEEF. busy[7] clears at edge T+1 if previously set.
- Round-robin fairness: all three valid continuously for 6 cycles → grant order 0,1,2,0,1,2. With WBARB_FIXED_PRIO_EN, the order is 0,0,0,… and requester 2 is never granted.
- x0 drop: req 0 valid with rd=0 and wd=64'h1 → req_ready[0]=1, rf_we stays 0 next cycle, ptr advances (next grant starts at index 1).
- Scoreboard collision: iss_valid=1, iss_rd=5 on the same edge that rf_we=1, rf_rd=5 → busy[5]=1 after the edge. iss_rd=0 never sets busy[0].
- Hold under contention: req 1 and req 2 both valid with ptr=0 → req 1 is granted; req 2 holds and is granted the next cycle with its original rd/wd delivered intact.
